// File: rtl/vga_timing_if.sv
// VGA timing bundle: raster position, sync/blank flags and pixel colour.
interface vga_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;

   modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_timing.sv
// VGA raster timing generator: horizontal/vertical counters with registered
// sync and blank flags that are aligned to the counters they describe.
module vga_timing #(
   parameter int unsigned H_ACTIVE = 800,
   parameter int unsigned H_FP     = 40,
   parameter int unsigned H_SYNC   = 128,
   parameter int unsigned H_BP     = 88,
   parameter int unsigned V_ACTIVE = 600,
   parameter int unsigned V_FP     = 1,
   parameter int unsigned V_SYNC   = 4,
   parameter int unsigned V_BP     = 23
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic frame_start,
   vga_if.out   vga_out
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // The counters are 11 bits wide; larger rasters cannot be represented.
   if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_bad_total
      $error("vga_timing: H_TOTAL/V_TOTAL must not exceed 2047");
   end

   localparam logic [10:0] H_LAST        = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST        = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_BLANK_START = 11'(H_ACTIVE);
   localparam logic [10:0] H_SYNC_START  = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] H_SYNC_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] V_BLANK_START = 11'(V_ACTIVE);
   localparam logic [10:0] V_SYNC_START  = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] V_SYNC_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

   logic [10:0] h_q, v_q;
   logic [10:0] h_nxt, v_nxt;
   logic        hsync_q, vsync_q, hblnk_q, vblnk_q, fs_q;
   logic        hsync_nxt, vsync_nxt, hblnk_nxt, vblnk_nxt, fs_nxt;

   // Next raster position: advance one pixel per enabled cycle, wrapping lines and frames.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      h_nxt = h_q;
      v_nxt = v_q;
      if (en) begin
         if (h_q == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v_q == V_LAST) ? 11'd0 : v_q + 11'd1;
         end else begin
            h_nxt = h_q + 11'd1;
         end
      end
   end

   // Flags are decoded from the next position so they register in step with the counters.
   always_comb begin
      hblnk_nxt = (h_nxt >= H_BLANK_START);
      hsync_nxt = (h_nxt >= H_SYNC_START) && (h_nxt < H_SYNC_END);
      vblnk_nxt = (v_nxt >= V_BLANK_START);
      vsync_nxt = (v_nxt >= V_SYNC_START) && (v_nxt < V_SYNC_END);
      fs_nxt    = (h_nxt == 11'd0) && (v_nxt == 11'd0);
   end

   // Output registers; reset parks the raster at (0,0) with frame_start raised.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q     <= '0;
         v_q     <= '0;
         hsync_q <= 1'b0;
         vsync_q <= 1'b0;
         hblnk_q <= 1'b0;
         vblnk_q <= 1'b0;
         fs_q    <= 1'b1;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so all registers update together.
         h_q     <= h_nxt;
         v_q     <= v_nxt;
         hsync_q <= hsync_nxt;
         vsync_q <= vsync_nxt;
         hblnk_q <= hblnk_nxt;
         vblnk_q <= vblnk_nxt;
         fs_q    <= fs_nxt;
      end
   end

   assign vga_out.hcount = h_q;
   assign vga_out.vcount = v_q;
   assign vga_out.hsync  = hsync_q;
   assign vga_out.vsync  = vsync_q;
   assign vga_out.hblnk  = hblnk_q;
   assign vga_out.vblnk  = vblnk_q;
   // Pixel content is filled in by downstream stages.
   assign vga_out.rgb    = 12'h000;
   assign frame_start    = fs_q;

endmodule
